// File: rtl/p_fxp_acc_seq.sv
// Sequencer that streams IN-lane beats through an external p_fxp_acc tree and accumulates the per-beat sums into one job result.
// Define P_FXP_ACC_SEQ_SAT_EN to clamp the partial sum on overflow; otherwise it wraps modulo 2^PREC.
module p_fxp_acc_seq #(
  parameter int IN    = 8,
  parameter int PREC  = 16,
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN*PREC-1:0]   in_data,
  output logic [IN*PREC-1:0]   tree_in,
  input  logic [PREC-1:0]      tree_sum,
  input  logic                 tree_ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PREC-1:0]      out_data,
  output logic                 out_ovf,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PREC-1:0] SAT_MAX = {1'b0, {(PREC-1){1'b1}}};
  localparam logic [PREC-1:0] SAT_MIN = {1'b1, {(PREC-1){1'b0}}};

  state_t           state_q;
  logic [PREC-1:0]  partial_q, partial_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q;
  logic             ovf_q, ovf_d;
  logic [PREC:0]    sum_w;
  logic             add_ovf;

  assign tree_in = in_data;

  // Sign-extend both operands by one bit so a disagreement of the top two bits flags overflow.
  always_comb begin
    sum_w   = {partial_q[PREC-1], partial_q} + {tree_sum[PREC-1], tree_sum};
    add_ovf = sum_w[PREC] ^ sum_w[PREC-1];
`ifdef P_FXP_ACC_SEQ_SAT_EN
    partial_d = add_ovf ? (sum_w[PREC] ? SAT_MIN : SAT_MAX) : sum_w[PREC-1:0];
`else
    partial_d = sum_w[PREC-1:0];
`endif
    ovf_d = ovf_q | tree_ovf | add_ovf;
    cnt_d = cnt_q + LEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      partial_q <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            partial_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            len_q     <= len;
            state_q   <= (len == '0) ? DONE : ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            partial_q <= partial_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            if (cnt_d == len_q) state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result outputs are forced to zero outside DONE so idle and reset read back clean.
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign out_data  = (state_q == DONE) ? partial_q : '0;
  assign out_ovf   = (state_q == DONE) ? ovf_q : 1'b0;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_p_fxp_acc_seq.sv
// Directed bench for p_fxp_acc_seq with a behavioural lane-sum tree model.
module tb_p_fxp_acc_seq;
  localparam int IN    = 8;
  localparam int PREC  = 16;
  localparam int LEN_W = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [LEN_W-1:0]    len;
  logic                in_valid;
  logic                in_ready;
  logic [IN*PREC-1:0]  in_data;
  logic [IN*PREC-1:0]  tree_in;
  logic [PREC-1:0]     tree_sum;
  logic                tree_ovf;
  logic                tree_ovf_force;
  logic                out_valid;
  logic                out_ready;
  logic [PREC-1:0]     out_data;
  logic                out_ovf;
  logic                busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  p_fxp_acc_seq #(.IN(IN), .PREC(PREC), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tree_in(tree_in), .tree_sum(tree_sum), .tree_ovf(tree_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .busy(busy)
  );

  // Tree model: wrapped sum of the lanes the DUT forwards.
  always_comb begin
    tree_sum = '0;
    for (int k = 0; k < IN; k++) tree_sum = tree_sum + tree_in[k*PREC +: PREC];
    tree_ovf = tree_ovf_force;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lane0(input logic [PREC-1:0] v);
    in_data = '0;
    in_data[PREC-1:0] = v;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  logic [PREC-1:0] exp_pos;
  logic [PREC-1:0] exp_neg;

  initial begin
`ifdef P_FXP_ACC_SEQ_SAT_EN
    exp_pos = 16'h7FFF;
    exp_neg = 16'h8000;
`else
    exp_pos = 16'h9000;
    exp_neg = 16'h2000;
`endif
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; tree_ovf_force = 1'b0;
    @(negedge clk);
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_ovf", 32'(out_ovf), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    step();

    // Three beats of 0x0100 split across lanes 0 and 7.
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0;
    chk("j1_busy", 32'(busy), 32'h1);
    chk("j1_in_ready", 32'(in_ready), 32'h1);
    in_valid = 1'b1;
    in_data = '0;
    in_data[0 +: PREC] = 16'h0080;
    in_data[7*PREC +: PREC] = 16'h0080;
    #1;
    chk("j1_tree_in", 32'(tree_in == in_data), 32'h1);
    step();
    step();
    chk("j1_valid_early", 32'(out_valid), 32'h0);
    step();
    in_valid = 1'b0;
    chk("j1_out_valid", 32'(out_valid), 32'h1);
    chk("j1_out_data", 32'(out_data), 32'h0300);
    chk("j1_out_ovf", 32'(out_ovf), 32'h0);
    chk("j1_in_ready_done", 32'(in_ready), 32'h0);
    consume();
    chk("j1_idle_busy", 32'(busy), 32'h0);
    chk("j1_idle_valid", 32'(out_valid), 32'h0);

    // Zero-length job.
    start = 1'b1; len = 8'd0; in_valid = 1'b1; lane0(16'h1234);
    step();
    start = 1'b0;
    chk("j0_out_valid", 32'(out_valid), 32'h1);
    chk("j0_out_data", 32'(out_data), 32'h0);
    chk("j0_out_ovf", 32'(out_ovf), 32'h0);
    chk("j0_in_ready", 32'(in_ready), 32'h0);
    in_valid = 1'b0;
    consume();

    // Positive add overflow; start coinciding with the consume is dropped.
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0;
    in_valid = 1'b1; lane0(16'h7000);
    step();
    lane0(16'h2000);
    step();
    in_valid = 1'b0;
    chk("pov_out_ovf", 32'(out_ovf), 32'h1);
    chk("pov_out_data", 32'(out_data), 32'(exp_pos));
    out_ready = 1'b1; start = 1'b1; len = 8'd5;
    step();
    out_ready = 1'b0; start = 1'b0;
    chk("pov_start_ignored", 32'(busy), 32'h0);
    step();
    chk("pov_still_idle", 32'(busy), 32'h0);

    // Negative add overflow: 0x9000 + 0x9000.
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0;
    in_valid = 1'b1; lane0(16'h9000);
    step();
    step();
    in_valid = 1'b0;
    chk("nov_out_ovf", 32'(out_ovf), 32'h1);
    chk("nov_out_data", 32'(out_data), 32'(exp_neg));
    consume();

    // Gapped valid, start pulses mid-job with a different len, stalled output.
    start = 1'b1; len = 8'd4;
    step();
    len = 8'd1;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      lane0(16'((i / 2 + 1) * 16));
      start = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("gap_out_valid", 32'(out_valid), 32'h1);
    chk("gap_out_data", 32'(out_data), 32'h00A0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; lane0(16'h1111);
      step();
      chk("gap_hold_data", 32'(out_data), 32'h00A0);
      chk("gap_hold_valid", 32'(out_valid), 32'h1);
    end
    start = 1'b0; in_valid = 1'b0;
    consume();
    chk("gap_idle", 32'(busy), 32'h0);

    // Reset after two of four beats.
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    in_valid = 1'b1; lane0(16'h0100);
    step();
    step();
    reset = 1'b1; in_valid = 1'b0; start = 1'b1; out_ready = 1'b1;
    step();
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_in_ready", 32'(in_ready), 32'h0);
    chk("mrst_out_valid", 32'(out_valid), 32'h0);
    chk("mrst_out_data", 32'(out_data), 32'h0);
    chk("mrst_out_ovf", 32'(out_ovf), 32'h0);
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    in_valid = 1'b1; lane0(16'hFF00);
    step();
    in_valid = 1'b0;
    chk("post_rst_data", 32'(out_data), 32'hFF00);
    chk("post_rst_ovf", 32'(out_ovf), 32'h0);
    consume();

    // Tree overflow on one beat only.
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0;
    in_valid = 1'b1; lane0(16'h0100); tree_ovf_force = 1'b1;
    step();
    tree_ovf_force = 1'b0; lane0(16'h0200);
    step();
    in_valid = 1'b0;
    chk("tov_out_ovf", 32'(out_ovf), 32'h1);
    chk("tov_out_data", 32'(out_data), 32'h0300);
    consume();
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    in_valid = 1'b1; lane0(16'h0005);
    step();
    in_valid = 1'b0;
    chk("tov_next_ovf", 32'(out_ovf), 32'h0);
    chk("tov_next_data", 32'(out_data), 32'h0005);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
